// File: rtl/led_pulse_driver.sv
// LED pulse stretcher: turns single-cycle event flags into LED pulses that last
// HOLD_TICKS prescaler ticks. Each channel has its own counter; all channels
// share one free-running prescaler.
module led_pulse_driver #(
  parameter int unsigned NUM_CHANNELS = 1,
  parameter int unsigned PRESCALE     = 50000,
  parameter int unsigned HOLD_TICKS   = 250,
  parameter int unsigned RETRIGGER    = 1
) (
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic                    clear,
  input  logic [NUM_CHANNELS-1:0] event_in,
  output logic [NUM_CHANNELS-1:0] led,
  output logic                    busy
);

  // A width of 1 still works when PRESCALE is 1: the counter sits at 0 and ticks every cycle.
  localparam int unsigned PsW  = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int unsigned CntW = $clog2(HOLD_TICKS + 1);

  localparam logic [PsW-1:0]  PsMax   = PsW'(PRESCALE - 1);
  localparam logic [CntW-1:0] CntLoad = CntW'(HOLD_TICKS);
  localparam logic [CntW-1:0] CntOne  = CntW'(1);

  logic [PsW-1:0]          ps_q, ps_d;
  logic                    tick;
  logic [CntW-1:0]         cnt_q [NUM_CHANNELS];
  logic [CntW-1:0]         cnt_d [NUM_CHANNELS];
  logic [NUM_CHANNELS-1:0] led_q, led_d;
  logic                    busy_q, busy_d;

  assign tick = (ps_q == PsMax);

  // Prescaler next state: wraps at PRESCALE-1; clear forces it back to 0.
  always_comb begin
    ps_d = ps_q + PsW'(1);
    if (clear || tick) begin
      ps_d = '0;
    end
  end

  // Per-channel next state: clear, then load, then decrement on tick.
  always_comb begin
    cnt_d = cnt_q;
    led_d = led_q;
    for (int i = 0; i < NUM_CHANNELS; i++) begin
      if (clear) begin
        cnt_d[i] = '0;
        led_d[i] = 1'b0;
      end else if (event_in[i] && ((cnt_q[i] == '0) || (RETRIGGER != 0))) begin
        cnt_d[i] = CntLoad;
        led_d[i] = 1'b1;
      end else if (tick && (cnt_q[i] != '0)) begin
        cnt_d[i] = cnt_q[i] - CntOne;
        led_d[i] = (cnt_q[i] != CntOne);
      end
    end
    // Computed from next-state LED bits so busy never lags led.
    busy_d = |led_d;
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      ps_q   <= '0;
      led_q  <= '0;
      busy_q <= 1'b0;
      for (int i = 0; i < NUM_CHANNELS; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      ps_q   <= ps_d;
      led_q  <= led_d;
      busy_q <= busy_d;
      for (int i = 0; i < NUM_CHANNELS; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  assign led  = led_q;
  assign busy = busy_q;

endmodule

// File: tb/tb_led_pulse_driver.sv
// Directed bench for led_pulse_driver. Three instances share the stimulus:
// dut_a (PRESCALE=1, HOLD=4, retrigger), dut_b (same, no retrigger) and
// dut_c (PRESCALE=4, HOLD=3, retrigger).
module tb_led_pulse_driver;

  logic       clock   = 1'b0;
  logic       reset_n = 1'b1;
  logic       clear   = 1'b0;
  logic [1:0] ev      = 2'b00;

  logic [1:0] led_a, led_b, led_c;
  logic       busy_a, busy_b, busy_c;

  int errors = 0;
  int checks = 0;

  led_pulse_driver #(
    .NUM_CHANNELS(2), .PRESCALE(1), .HOLD_TICKS(4), .RETRIGGER(1)
  ) dut_a (
    .clock(clock), .reset_n(reset_n), .clear(clear), .event_in(ev),
    .led(led_a), .busy(busy_a)
  );

  led_pulse_driver #(
    .NUM_CHANNELS(2), .PRESCALE(1), .HOLD_TICKS(4), .RETRIGGER(0)
  ) dut_b (
    .clock(clock), .reset_n(reset_n), .clear(clear), .event_in(ev),
    .led(led_b), .busy(busy_b)
  );

  led_pulse_driver #(
    .NUM_CHANNELS(2), .PRESCALE(4), .HOLD_TICKS(3), .RETRIGGER(1)
  ) dut_c (
    .clock(clock), .reset_n(reset_n), .clear(clear), .event_in(ev),
    .led(led_c), .busy(busy_c)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Advance one active edge and settle just past it.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  initial begin
    logic [1:0] exp_a;
    logic [1:0] exp_b;
    logic [1:0] exp_c;

    // T1: reset with all events high, then release.
    #1;
    reset_n = 1'b0;
    ev      = 2'b11;
    step();
    step();
    check("t1_led_a", led_a, 0);
    check("t1_busy_a", busy_a, 0);
    check("t1_led_c", led_c, 0);
    reset_n = 1'b1;
    ev      = 2'b00;
    step();
    step();
    check("t1_rel_led_a", led_a, 0);
    check("t1_rel_busy_a", busy_a, 0);
    check("t1_rel_led_b", led_b, 0);

    // T2: single event, 4-cycle pulse on ch0 only.
    ev = 2'b01;
    step();
    ev = 2'b00;
    check("t2_led_a_e0", led_a, 1);
    check("t2_busy_a_e0", busy_a, 1);
    for (int k = 1; k <= 4; k++) begin
      step();
      exp_a = (k <= 3) ? 2'b01 : 2'b00;
      check("t2_led_a", led_a, exp_a);
      check("t2_busy_a", busy_a, int'(|exp_a));
    end
    step();

    // T3: second event two edges later; retrigger extends, no-retrigger ignores.
    ev = 2'b01;
    step();
    ev = 2'b00;
    step();
    ev = 2'b01;
    step();
    ev = 2'b00;
    check("t3_led_a_e2", led_a, 1);
    check("t3_led_b_e2", led_b, 1);
    for (int k = 3; k <= 6; k++) begin
      step();
      exp_a = (k <= 5) ? 2'b01 : 2'b00;
      exp_b = (k <= 3) ? 2'b01 : 2'b00;
      check("t3_led_a", led_a, exp_a);
      check("t3_led_b", led_b, exp_b);
      check("t3_busy_b", busy_b, int'(|exp_b));
    end
    step();

    // T4: clear wins over a same-cycle event; later event gives a full pulse.
    ev = 2'b01;
    step();
    ev = 2'b00;
    step();
    check("t4_led_a_mid", led_a, 1);
    clear = 1'b1;
    ev    = 2'b01;
    step();
    clear = 1'b0;
    ev    = 2'b00;
    check("t4_led_a_clr", led_a, 0);
    check("t4_busy_a_clr", busy_a, 0);
    check("t4_led_b_clr", led_b, 0);
    step();
    check("t4_led_a_idle", led_a, 0);
    ev = 2'b01;
    step();
    ev = 2'b00;
    check("t4_led_a_e4", led_a, 1);
    for (int k = 5; k <= 8; k++) begin
      step();
      exp_a = (k <= 7) ? 2'b01 : 2'b00;
      check("t4_led_a", led_a, exp_a);
    end

    // T5: clear zeroes the prescaler (ticks then land on edges 4, 8, 12, 16).
    // ch0 loads at edge 2 (10 cycles), ch1 at edge 4 with a tick (12 cycles).
    clear = 1'b1;
    step();
    clear = 1'b0;
    for (int k = 1; k <= 17; k++) begin
      ev = (k == 2) ? 2'b01 : ((k == 4) ? 2'b10 : 2'b00);
      step();
      ev = 2'b00;
      exp_c[0] = (k >= 2) && (k <= 11);
      exp_c[1] = (k >= 4) && (k <= 15);
      check("t5_led_c", led_c, exp_c);
      check("t5_busy_c", busy_c, int'(|exp_c));
    end

    // T6: asynchronous reset mid-pulse between edges, then a fresh pulse.
    ev = 2'b01;
    step();
    ev = 2'b00;
    step();
    check("t6_led_a_pre", led_a, 1);
    check("t6_led_c_pre", led_c, 1);
    #2;
    reset_n = 1'b0;
    #1;
    check("t6_led_a_rst", led_a, 0);
    check("t6_busy_a_rst", busy_a, 0);
    check("t6_led_b_rst", led_b, 0);
    check("t6_led_c_rst", led_c, 0);
    check("t6_busy_c_rst", busy_c, 0);
    #1;
    reset_n = 1'b1;
    // First edge after release samples the event with the prescaler at 0.
    for (int k = 1; k <= 13; k++) begin
      ev = (k == 1) ? 2'b01 : 2'b00;
      step();
      ev = 2'b00;
      exp_a = (k <= 4) ? 2'b01 : 2'b00;
      exp_c = (k <= 11) ? 2'b01 : 2'b00;
      check("t6_led_a", led_a, exp_a);
      check("t6_led_c", led_c, exp_c);
      check("t6_busy_c", busy_c, int'(|exp_c));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
